// File: rtl/core_msg_rx_pkg.sv
// core_msg_rx_pkg: message-bus field masks, receiver FSM states and frame helpers
package core_msg_rx_pkg;
    localparam logic [15:0] SCHED_IFNUM_MASK  = 16'h003F;
    localparam logic [15:0] SCHED_FENCE_MASK  = 16'h00C0;
    localparam int          SCHED_FENCE_SHIFT = 6;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_MASK,
        ST_R0V,
        ST_R0D,
        ST_INSTR,
        ST_DONE
    } rx_state_e;

    function automatic logic [10:0] task_words(input logic [5:0] n_if);
        return {1'b0, n_if, 4'b0000};
    endfunction
endpackage

// File: rtl/core_msg_rx.sv
// core_msg_rx: per-core parser of the scheduler frame stream; loads r0 and imem, then starts the task
module core_msg_rx
    import core_msg_rx_pkg::*;
#(
    parameter int CORE_ID    = 0,
    parameter int CORE_NUM   = 16,
    parameter int INSTR_SIZE = 16,
    parameter int FRAME_SIZE = 16,
    parameter int FRAME_NUM  = 64,
    parameter int R0_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  msg_valid,
    input  logic [INSTR_SIZE-1:0] mess_to_core,
    input  logic                  core_busy,
    output logic                  core_reading,
    output logic                  core_ready,
    output logic                  r0_we,
    output logic [INSTR_SIZE-1:0] r0_wdata,
    output logic                  imem_we,
    output logic [9:0]            imem_addr,
    output logic [INSTR_SIZE-1:0] imem_wdata,
    output logic                  task_start,
    output logic [1:0]            task_fence,
    output logic [10:0]           task_len,
    output logic                  proto_err
);
    localparam int CNT_W = $clog2(R0_DEPTH);
    localparam logic [CNT_W-1:0] R0_SLOT = CNT_W'(CORE_ID % R0_DEPTH);
    localparam logic [CNT_W-1:0] R0_LAST = CNT_W'(R0_DEPTH - 1);

    rx_state_e             state_q, state_d;
    logic [5:0]            n_if_q, n_if_d;
    logic [1:0]            fence_q, fence_d;
    logic                  sel_q, sel_d;
    logic                  r0_sel_q, r0_sel_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [9:0]            widx_q, widx_d;
    logic                  proto_err_q, proto_err_d;
    logic                  r0_we_q, r0_we_d;
    logic [INSTR_SIZE-1:0] r0_wdata_q, r0_wdata_d;
    logic                  imem_we_q, imem_we_d;
    logic [9:0]            imem_addr_q, imem_addr_d;
    logic [INSTR_SIZE-1:0] imem_wdata_q, imem_wdata_d;
    logic                  task_start_q, task_start_d;
    logic [1:0]            task_fence_q, task_fence_d;
    logic [10:0]           task_len_q, task_len_d;
    logic [CORE_NUM-1:0]   mask_w;
    logic                  last_instr;

    assign mask_w     = mess_to_core[CORE_NUM-1:0];
    assign last_instr = widx_q == 10'(task_words(n_if_q) - 11'd1);

    always_comb begin
        state_d      = state_q;
        n_if_d       = n_if_q;
        fence_d      = fence_q;
        sel_d        = sel_q;
        r0_sel_d     = r0_sel_q;
        cnt_d        = cnt_q;
        widx_d       = widx_q;
        proto_err_d  = proto_err_q;
        r0_we_d      = 1'b0;
        r0_wdata_d   = r0_wdata_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        task_start_d = 1'b0;
        task_fence_d = task_fence_q;
        task_len_d   = task_len_q;
        case (state_q)
            ST_HDR: if (msg_valid) begin
                n_if_d  = 6'(mess_to_core & SCHED_IFNUM_MASK);
                fence_d = 2'((mess_to_core & SCHED_FENCE_MASK) >> SCHED_FENCE_SHIFT);
                widx_d  = '0;
                state_d = ST_MASK;
            end
            ST_MASK: if (msg_valid) begin
                // a busy core must not accept a new program, so selection is dropped and flagged
                sel_d       = mask_w[CORE_ID] & ~core_busy;
                proto_err_d = proto_err_q | (mask_w[CORE_ID] & core_busy);
                state_d     = ST_R0V;
            end
            ST_R0V: if (msg_valid) begin
                r0_sel_d = sel_q & mask_w[CORE_ID];
                cnt_d    = '0;
                state_d  = ST_R0D;
            end
            ST_R0D: if (msg_valid) begin
                r0_we_d    = r0_sel_q && cnt_q == R0_SLOT;
                r0_wdata_d = r0_we_d ? mess_to_core : r0_wdata_q;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == R0_LAST)
                    state_d = n_if_q != '0 ? ST_INSTR : ST_DONE;
            end
            ST_INSTR: if (msg_valid) begin
                imem_we_d    = sel_q;
                imem_addr_d  = sel_q ? widx_q : imem_addr_q;
                imem_wdata_d = sel_q ? mess_to_core : imem_wdata_q;
                widx_d       = widx_q + 10'd1;
                state_d      = last_instr ? ST_DONE : ST_INSTR;
            end
            ST_DONE: begin
                task_start_d = sel_q;
                task_fence_d = fence_q;
                task_len_d   = sel_q ? task_words(n_if_q) : 11'd0;
                proto_err_d  = proto_err_q | msg_valid;
                state_d      = ST_HDR;
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_HDR;
            n_if_q       <= '0;
            fence_q      <= '0;
            sel_q        <= 1'b0;
            r0_sel_q     <= 1'b0;
            cnt_q        <= '0;
            widx_q       <= '0;
            proto_err_q  <= 1'b0;
            r0_we_q      <= 1'b0;
            r0_wdata_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            task_start_q <= 1'b0;
            task_fence_q <= '0;
            task_len_q   <= '0;
        end else begin
            state_q      <= state_d;
            n_if_q       <= n_if_d;
            fence_q      <= fence_d;
            sel_q        <= sel_d;
            r0_sel_q     <= r0_sel_d;
            cnt_q        <= cnt_d;
            widx_q       <= widx_d;
            proto_err_q  <= proto_err_d;
            r0_we_q      <= r0_we_d;
            r0_wdata_q   <= r0_wdata_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            task_start_q <= task_start_d;
            task_fence_q <= task_fence_d;
            task_len_q   <= task_len_d;
        end
    end

    assign core_reading = state_q != ST_DONE;
    assign core_ready   = ~core_busy & ~(state_q == ST_DONE & sel_q);
    assign r0_we        = r0_we_q;
    assign r0_wdata     = r0_wdata_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign task_start   = task_start_q;
    assign task_fence   = task_fence_q;
    assign task_len     = task_len_q;
    assign proto_err    = proto_err_q;
endmodule

// File: tb/tb_core_msg_rx.sv
// tb_core_msg_rx: directed + randomized frame streams against a frame-level reference model
module tb_core_msg_rx;
    localparam int ID = 3;

    logic        clk = 0;
    logic        reset_n = 0;
    logic        msg_valid = 0;
    logic [15:0] mess_to_core = 0;
    logic        core_busy = 0;
    logic        core_reading, core_ready, r0_we, imem_we, task_start, proto_err;
    logic [15:0] r0_wdata, imem_wdata;
    logic [9:0]  imem_addr;
    logic [1:0]  task_fence;
    logic [10:0] task_len;

    int checks = 0;
    int failures = 0;
    bit err_model = 0;

    logic [15:0] r0_q[$];
    logic [9:0]  ia_q[$];
    logic [15:0] id_q[$];
    logic [10:0] tl_q[$];
    logic [1:0]  tf_q[$];
    int cyc = 0, last_imem_cyc = -1, start_cyc = -1, done_cnt = 0;
    logic done_ready = 0;

    core_msg_rx #(.CORE_ID(ID)) dut (
        .clk(clk), .reset_n(reset_n), .msg_valid(msg_valid), .mess_to_core(mess_to_core),
        .core_busy(core_busy), .core_reading(core_reading), .core_ready(core_ready),
        .r0_we(r0_we), .r0_wdata(r0_wdata), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .task_start(task_start), .task_fence(task_fence),
        .task_len(task_len), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (reset_n) begin
            if (r0_we) r0_q.push_back(r0_wdata);
            if (imem_we) begin
                ia_q.push_back(imem_addr);
                id_q.push_back(imem_wdata);
                last_imem_cyc = cyc;
            end
            if (task_start) begin
                tl_q.push_back(task_len);
                tf_q.push_back(task_fence);
                start_cyc = cyc;
            end
            if (!core_reading) begin
                done_cnt++;
                done_ready = core_ready;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        r0_q.delete(); ia_q.delete(); id_q.delete(); tl_q.delete(); tf_q.delete();
        last_imem_cyc = -1; start_cyc = -1; done_cnt = 0;
    endtask

    task automatic send(input logic [15:0] w, input int stall_max);
        int g, n;
        g = stall_max > 0 ? int'($urandom_range(0, stall_max)) : 0;
        repeat (g) begin
            @(negedge clk);
            msg_valid = 0;
        end
        @(negedge clk);
        n = 0;
        while (!core_reading && n < 8) begin
            msg_valid = 0;
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 8) else begin
            failures++;
            $error("FAIL reading_timeout observed=%0d expected<8", n);
        end
        msg_valid = 1;
        mess_to_core = w;
    endtask

    task automatic idle();
        @(negedge clk);
        msg_valid = 0;
    endtask

    // Frame-level model: selection, r0 slot, program words, length and fence from header fields
    task automatic run_stream(input logic [15:0] hdr, mask, vec, input int stall_max,
                              input bit busy, input bit fixed_r0);
        logic [15:0] r0w[8];
        logic [15:0] ins[$];
        int nw, bad;
        bit sel, r0x;
        for (int i = 0; i < 8; i++) r0w[i] = fixed_r0 ? 16'hA0 + 16'(i) : 16'($urandom);
        nw = int'(hdr[5:0]) * 16;
        for (int i = 0; i < nw; i++) ins.push_back(16'($urandom));
        sel = mask[ID] && !busy;
        r0x = sel && vec[ID];
        err_model = err_model | (mask[ID] && busy);
        clr();
        core_busy = busy;
        send(hdr, stall_max);
        send(mask, stall_max);
        send(vec, stall_max);
        for (int i = 0; i < 8; i++) send(r0w[i], stall_max);
        for (int i = 0; i < nw; i++) send(ins[i], stall_max);
        idle();
        repeat (4) @(negedge clk);
        chk("r0_cnt", r0_q.size(), r0x ? 1 : 0);
        if (r0x && r0_q.size() == 1) chk("r0_data", r0_q[0], r0w[ID % 8]);
        chk("imem_cnt", ia_q.size(), sel ? nw : 0);
        bad = 0;
        for (int i = 0; i < ia_q.size() && i < ins.size(); i++)
            if (ia_q[i] !== 10'(i) || id_q[i] !== ins[i]) bad++;
        chk("imem_words_bad", bad, 0);
        chk("start_cnt", tl_q.size(), sel ? 1 : 0);
        if (sel && tl_q.size() == 1) begin
            chk("task_len", tl_q[0], nw);
            chk("task_fence", tf_q[0], hdr[7:6]);
        end
        chk("start_after_imem", (start_cyc >= 0 && last_imem_cyc >= start_cyc) ? 1 : 0, 0);
        chk("done_cycles", done_cnt, 1);
        chk("ready_in_done", done_ready, busy ? 0 : !sel);
        chk("proto_err", proto_err, err_model);
        chk("reading_after", core_reading, 1);
        chk("ready_after", core_ready, !busy);
        core_busy = 0;
    endtask

    initial begin
        #12;
        chk("rst_reading", core_reading, 1);
        chk("rst_ready", core_ready, 1);
        chk("rst_r0_we", r0_we, 0);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_start", task_start, 0);
        chk("rst_err", proto_err, 0);
        @(negedge clk);
        reset_n = 1;
        run_stream(16'h0002, 16'h0008, 16'h0008, 0, 0, 1);
        run_stream(16'h0002, 16'h0004, 16'h0008, 0, 0, 1);
        run_stream(16'h0040, 16'h0008, 16'h0008, 0, 0, 1);
        run_stream(16'h0002, 16'h0008, 16'h0008, 3, 0, 1);
        run_stream({8'($urandom), 2'($urandom), 6'd63}, 16'($urandom) | 16'h0008,
                   16'($urandom) | 16'h0008, 1, 0, 0);
        for (int k = 0; k < 6; k++)
            run_stream({8'($urandom), 2'($urandom), 6'($urandom_range(0, 4))},
                       16'($urandom), 16'($urandom), 2, 0, 0);
        run_stream(16'h0081, 16'h0008, 16'h0008, 1, 1, 0);
        // reset in the middle of the instruction frames
        send(16'h0002, 0); send(16'h0008, 0); send(16'h0008, 0);
        for (int i = 0; i < 8; i++) send(16'(i), 0);
        for (int i = 0; i < 10; i++) send(16'h5000 + 16'(i), 0);
        @(negedge clk);
        msg_valid = 0;
        #2 reset_n = 0;
        #1;
        chk("mid_rst_imem_we", imem_we, 0);
        chk("mid_rst_addr", imem_addr, 0);
        chk("mid_rst_err", proto_err, 0);
        chk("mid_rst_reading", core_reading, 1);
        chk("mid_rst_len", task_len, 0);
        err_model = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        run_stream(16'h0001, 16'h0008, 16'h0008, 1, 0, 0);
        // word presented while the receiver is in its start cycle
        clr();
        send(16'h0000, 0); send(16'h0008, 0); send(16'h0008, 0);
        for (int i = 0; i < 8; i++) send(16'hB0 + 16'(i), 0);
        @(negedge clk);
        mess_to_core = 16'h1234;
        @(negedge clk);
        msg_valid = 0;
        repeat (3) @(negedge clk);
        err_model = 1;
        chk("done_drop_err", proto_err, 1);
        chk("done_drop_start", tl_q.size(), 1);
        chk("done_drop_r0", r0_q.size() == 1 ? r0_q[0] : 16'hFFFF, 16'hB3);
        run_stream(16'h0001, 16'h0008, 16'h0008, 1, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
